// File: rtl/sign_extender_if.sv
// sign_extender_if: bundles the immediate-extension signals between a
// producer (decode stage or bench) and the sign_extender block.
//
//   in        producer -> extender  immediate field (IN_WIDTH)
//   mode      producer -> extender  extension select (2)
//   in_valid  producer -> extender  qualifies in/mode for the registered path
//   out       extender -> producer  combinational extended word (OUT_WIDTH)
//   is_neg    extender -> producer  combinational MSB of out
//   out_q     extender -> producer  registered extended word (OUT_WIDTH)
//   out_valid extender -> producer  registered, out_q holds a fresh result
//
// Handshake: in_valid is sampled on every rising clk edge. A sample with
// in_valid=1 is a transfer; there is no ready/backpressure, so the extender
// accepts every valid beat and answers it with out_valid=1 exactly one
// cycle later.
interface sign_extender_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
);
    logic [IN_WIDTH-1:0]  in;
    logic [1:0]           mode;
    logic                 in_valid;
    logic [OUT_WIDTH-1:0] out;
    logic                 is_neg;
    logic [OUT_WIDTH-1:0] out_q;
    logic                 out_valid;

    modport master (
        output in,
        output mode,
        output in_valid,
        input  out,
        input  is_neg,
        input  out_q,
        input  out_valid
    );

    modport slave (
        input  in,
        input  mode,
        input  in_valid,
        output out,
        output is_neg,
        output out_q,
        output out_valid
    );
endinterface

// File: rtl/sign_extender.sv
// sign_extender: widens an instruction immediate to the datapath word.
//
//   clk    rising-edge clock
//   reset  asynchronous active-high; clears out_q/out_valid only
//   bus    sign_extender_if.slave
//            in/mode     -> out/is_neg  combinational, zero latency
//            in_valid    -> out_q/out_valid one cycle later
//
// mode 00 sign-extend, 01 zero-extend, 10 byte sign-extend (in[7] is the
// sign, upper input bits ignored), 11 upper-load (in placed in the top
// IN_WIDTH bits, low bits zero).
module sign_extender #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    sign_extender_if.slave  bus
);
    // Byte mode needs at least 8 input bits and upper-load needs the
    // immediate to fit in the top half of the word.
    if (IN_WIDTH < 8 || 2 * IN_WIDTH > OUT_WIDTH) begin : g_param_check
        $error("sign_extender: IN_WIDTH must be in 8..OUT_WIDTH/2");
    end

    localparam int EXT_W  = OUT_WIDTH - IN_WIDTH;
    localparam int BYTE_W = OUT_WIDTH - 8;

    logic [OUT_WIDTH-1:0] ext;
    logic [OUT_WIDTH-1:0] res_d, res_q;
    logic                 valid_d, valid_q;

    // Combinational extension; does not depend on clk or reset.
    always_comb begin
        ext = '0;
        case (bus.mode)
            2'b00: ext = {{EXT_W{bus.in[IN_WIDTH-1]}}, bus.in};
            2'b01: ext = {{EXT_W{1'b0}}, bus.in};
            2'b10: ext = {{BYTE_W{bus.in[7]}}, bus.in[7:0]};
            2'b11: ext = {bus.in, {EXT_W{1'b0}}};
            default: ext = '0;
        endcase
    end

    // out_q holds its last value when no valid beat arrives; out_valid
    // only marks the cycle right after a capture.
    always_comb begin
        res_d   = res_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            res_d = ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out       = ext;
    assign bus.is_neg    = ext[OUT_WIDTH-1];
    assign bus.out_q     = res_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_sign_extender.sv
module tb_sign_extender;
    localparam int IW = 16;
    localparam int OW = 32;
    localparam int NV = 13;

    logic clk;
    logic reset;
    logic clk_en;

    int checks;
    int errors;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp_hold;
    logic          exp_valid;

    sign_extender_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    sign_extender #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Directed vectors with hand-computed results.
    logic [IW-1:0] vin   [NV] = '{16'h1AAB, 16'h9AAB, 16'h9AAB, 16'h9AAB, 16'h9AAB,
                                  16'h1A2B, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000,
                                  16'h0000, 16'h0000, 16'h0000};
    logic [1:0]    vmode [NV] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3,
                                  2'd2, 2'd0, 2'd0, 2'd0, 2'd0,
                                  2'd1, 2'd2, 2'd3};
    logic [OW-1:0] vexp  [NV] = '{32'h00001AAB, 32'hFFFF9AAB, 32'h00009AAB, 32'hFFFFFFAB,
                                  32'h9AAB0000, 32'h0000002B, 32'hFFFF8000, 32'h00007FFF,
                                  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000,
                                  32'h00000000};

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // Extension expressed as integer arithmetic on the immediate's value.
    function automatic logic [OW-1:0] model(input logic [IW-1:0] d, input logic [1:0] m);
        longint v;
        v = longint'(d);
        case (m)
            2'd0: if (v >= 32768) v = v - 65536;
            2'd1: v = v;
            2'd2: begin
                v = v % 256;
                if (v >= 128) v = v - 256;
            end
            default: v = v * 65536;
        endcase
        return v[OW-1:0];
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [IW-1:0] d, input logic [1:0] m);
        bus.in_valid = v;
        bus.in       = d;
        bus.mode     = m;
        if (v) exp_q.push_back(model(d, m));
    endtask

    // Expected registered state: a beat accepted at an edge becomes the
    // held result; reset throws away anything pending.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            exp_hold  = '0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = bus.in_valid;
            if (bus.in_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL model_queue: got empty, expected entry at %0t", $time);
                end else begin
                    exp_hold = exp_q.pop_front();
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        chk("cmp_out",       bus.out, model(bus.in, bus.mode));
        chk("cmp_is_neg",    {31'd0, bus.is_neg}, {31'd0, model(bus.in, bus.mode) >= 32'h8000_0000});
        chk("cmp_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
        chk("cmp_out_q",     bus.out_q, exp_hold);
    end

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        reset  = 1'b1;
        bus.in_valid = 1'b0;
        bus.in       = '0;
        bus.mode     = 2'd0;
        #1;
        chk("reset_out_q",     bus.out_q, 32'h0);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'h0);

        // Combinational path, no clock, reset held.
        for (int i = 0; i < NV; i++) begin
            bus.in   = vin[i];
            bus.mode = vmode[i];
            #1;
            chk($sformatf("comb_out_%0d", i), bus.out, vexp[i]);
            chk($sformatf("comb_neg_%0d", i), {31'd0, bus.is_neg}, {31'd0, vexp[i][OW-1]});
            chk($sformatf("model_pin_%0d", i), model(vin[i], vmode[i]), vexp[i]);
        end
        chk("reset_hold_out_q", bus.out_q, 32'h0);

        #5;
        reset  = 1'b0;
        bus.in = '0;
        clk_en = 1'b1;

        // Single beat then idle.
        @(posedge clk); #2 drive(1'b1, 16'h9AAB, 2'd0);
        @(posedge clk); #2 drive(1'b0, 16'h0000, 2'd0);
        chk("reg_out_q",       bus.out_q, 32'hFFFF9AAB);
        chk("reg_out_valid",   {31'd0, bus.out_valid}, 32'h1);
        @(posedge clk); #2;
        chk("idle_out_valid",  {31'd0, bus.out_valid}, 32'h0);
        chk("idle_out_q_hold", bus.out_q, 32'hFFFF9AAB);

        // Back-to-back beats.
        @(posedge clk); #2 drive(1'b1, 16'h0001, 2'd0);
        @(posedge clk); #2 drive(1'b1, 16'h8001, 2'd0);
        chk("b2b_0", bus.out_q, 32'h00000001);
        @(posedge clk); #2 drive(1'b1, 16'h00FF, 2'd2);
        chk("b2b_1", bus.out_q, 32'hFFFF8001);
        chk("b2b_1_valid", {31'd0, bus.out_valid}, 32'h1);
        @(posedge clk); #2 drive(1'b0, 16'h0000, 2'd0);
        chk("b2b_2", bus.out_q, 32'hFFFFFFFF);
        chk("b2b_2_valid", {31'd0, bus.out_valid}, 32'h1);

        // Whole vector table through the registered path, streamed.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #2 drive(1'b1, vin[i], vmode[i]);
        end
        @(posedge clk); #2 drive(1'b0, 16'h0000, 2'd0);

        // Asynchronous reset while a result is valid.
        @(posedge clk); #2 drive(1'b1, 16'h9AAB, 2'd3);
        @(posedge clk); #2 drive(1'b0, 16'h9AAB, 2'd3);
        #1;
        chk("pre_rst_out_q",     bus.out_q, 32'h9AAB0000);
        chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'h1);
        reset = 1'b1;
        #1;
        chk("async_rst_out_q",     bus.out_q, 32'h0);
        chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'h0);
        chk("async_rst_out",       bus.out, 32'h9AAB0000);
        @(posedge clk); #2;
        chk("rst_edge_out_q", bus.out_q, 32'h0);
        reset = 1'b0;
        drive(1'b1, 16'h7FFF, 2'd1);
        @(posedge clk); #2 drive(1'b0, 16'h7FFF, 2'd1);
        chk("post_rst_out_q",     bus.out_q, 32'h00007FFF);
        chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'h1);

        // Reset arriving before the capturing edge discards the beat.
        @(posedge clk); #2 drive(1'b1, 16'h1234, 2'd0);
        #1 reset = 1'b1;
        #1;
        chk("discard_valid", {31'd0, bus.out_valid}, 32'h0);
        drive(1'b0, 16'h1234, 2'd0);
        reset = 1'b0;
        @(posedge clk); #2;
        chk("discard_out_valid", {31'd0, bus.out_valid}, 32'h0);
        chk("discard_out_q",     bus.out_q, 32'h0);

        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
